// File: rtl/dff_pipe_elastic.sv
// Elastic valid/ready register pipeline, WIDTH bits x DEPTH stages; a word reaches out_valid DEPTH cycles after its accept cycle.
// Stalls collapse bubbles first; in_ready drops only when all stages are full and out_ready is low; clr flushes synchronously.
module dff_pipe_elastic #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  if (DEPTH < 1) begin : g_depth_check
    $error("dff_pipe_elastic: DEPTH must be at least 1");
  end

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] en;
  logic [WIDTH-1:0] d [DEPTH];
  logic             in_xfer;
  logic             out_xfer;

  // A stage may load when it is empty or the stage after it is moving.
  always_comb begin : ready_chain
    logic nxt_en;
    nxt_en = out_ready;
    en     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      en[i]  = !v[i] | nxt_en;
      nxt_en = en[i];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             src_v;
    logic [WIDTH-1:0] src_d;
    logic             v_q;
    logic [WIDTH-1:0] d_q;

    if (i == 0) begin : g_head
      assign src_v = in_valid;
      assign src_d = in_data;
    end else begin : g_body
      assign src_v = v[i-1];
      assign src_d = d[i-1];
    end

    // Data only loads under a valid source so idle stages keep their last word.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (clr) begin
        v_q <= 1'b0;
      end else if (en[i]) begin
        v_q <= src_v;
        if (src_v) d_q <= src_d;
      end
    end

    assign v[i] = v_q;
    assign d[i] = d_q;
  end

  assign in_ready  = en[0] & !clr;
  assign out_valid = v[DEPTH-1] & !clr;
  assign out_data  = d[DEPTH-1];

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (in_xfer && !out_xfer) begin
      count <= count + CW'(1);
    end else if (out_xfer && !in_xfer) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_dff_pipe_elastic.sv
// Shared-stimulus bench for three pipeline depths (3, 4, 1); each instance has its own FIFO scoreboard.
module tb_dff_pipe_elastic;

  logic         clk;
  logic         rst;
  logic         clr;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_data;

  logic         a_ir, a_ov, b_ir, b_ov, c_ir, c_ov;
  logic [127:0] a_od, b_od, c_od;
  logic [1:0]   a_cnt;
  logic [2:0]   b_cnt;
  logic [0:0]   c_cnt;

  int tests = 0;
  int fails = 0;

  logic [127:0] q3[$];
  logic [127:0] q4[$];
  logic [127:0] q1[$];

  dff_pipe_elastic #(.WIDTH(128), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(a_ir), .in_data(in_data),
    .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od), .count(a_cnt)
  );

  dff_pipe_elastic #(.WIDTH(128), .DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(b_ir), .in_data(in_data),
    .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od), .count(b_cnt)
  );

  dff_pipe_elastic #(.WIDTH(128), .DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(c_ir), .in_data(in_data),
    .out_valid(c_ov), .out_ready(out_ready), .out_data(c_od), .count(c_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int n);
    return {4{n}} ^ {32'hDEAD_BEEF, 96'h0};
  endfunction

  // Scoreboards: pop on output transfer, push on input transfer, drop on flush/reset.
  always @(negedge clk) begin
    if (rst) q3.delete();
    else begin
      if (a_ov && out_ready) begin
        if (q3.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb3.empty: got word %0h, expected none", a_od);
        end else chk("sb3.data", a_od, q3.pop_front());
      end
      if (in_valid && a_ir) q3.push_back(in_data);
      if (clr) q3.delete();
    end
  end

  always @(negedge clk) begin
    if (rst) q4.delete();
    else begin
      if (b_ov && out_ready) begin
        if (q4.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb4.empty: got word %0h, expected none", b_od);
        end else chk("sb4.data", b_od, q4.pop_front());
      end
      if (in_valid && b_ir) q4.push_back(in_data);
      if (clr) q4.delete();
    end
  end

  always @(negedge clk) begin
    if (rst) q1.delete();
    else begin
      if (c_ov && out_ready) begin
        if (q1.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb1.empty: got word %0h, expected none", c_od);
        end else chk("sb1.data", c_od, q1.pop_front());
      end
      if (in_valid && c_ir) q1.push_back(in_data);
      if (clr) q1.delete();
    end
  end

  // One cycle: drive at posedge+1, check the selected instance at negedge.
  task automatic step(input logic iv, input logic [127:0] id, input logic ordy, input logic cl,
                      input int sel, input int e_ir, input int e_cnt, input int e_ov, input string tag);
    logic [127:0] air, acnt, aov;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    clr       = cl;
    @(negedge clk);
    case (sel)
      3:       begin air = 128'(a_ir); acnt = 128'(a_cnt); aov = 128'(a_ov); end
      4:       begin air = 128'(b_ir); acnt = 128'(b_cnt); aov = 128'(b_ov); end
      default: begin air = 128'(c_ir); acnt = 128'(c_cnt); aov = 128'(c_ov); end
    endcase
    chk($sformatf("%s.in_ready", tag), air, 128'(e_ir));
    chk($sformatf("%s.count", tag), acnt, 128'(e_cnt));
    chk($sformatf("%s.out_valid", tag), aov, 128'(e_ov));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    clr       = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst.out_valid", 128'(a_ov), 128'(0));
    chk("rst.out_data", a_od, 128'(0));
    chk("rst.count", 128'(a_cnt), 128'(0));
    chk("rst.in_ready", 128'(a_ir), 128'(1));
    chk("rst.count4", 128'(b_cnt), 128'(0));
    chk("rst.count1", 128'(c_cnt), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Latency: single word, out_valid on the third cycle after accept.
    step(1, pat(1), 1, 0, 3, 1, 0, 0, "lat0");
    step(0, '0,     1, 0, 3, 1, 1, 0, "lat1");
    step(0, '0,     1, 0, 3, 1, 1, 0, "lat2");
    step(0, '0,     1, 0, 3, 1, 1, 1, "lat3");

    // Streaming 0x1..0x10 back-to-back with out_ready held high.
    for (int j = 0; j < 20; j++) begin
      int acc;
      int pop;
      acc = (j < 16) ? j : 16;
      pop = ((j < 19) ? j : 19) - 3;
      if (pop < 0) pop = 0;
      step(j < 16, (j < 16) ? 128'(j + 1) : 128'(0), 1, 0, 3, 1, acc - pop,
           (j >= 3 && j < 19) ? 1 : 0, $sformatf("st%0d", j));
    end

    // Back-pressure fill: A,B,C accepted, D waits until out_ready rises.
    step(1, pat(10), 0, 0, 3, 1, 0, 0, "bp0");
    step(1, pat(11), 0, 0, 3, 1, 1, 0, "bp1");
    step(1, pat(12), 0, 0, 3, 1, 2, 0, "bp2");
    step(1, pat(13), 0, 0, 3, 0, 3, 1, "bp3");
    step(1, pat(13), 0, 0, 3, 0, 3, 1, "bp4");
    step(1, pat(13), 1, 0, 3, 1, 3, 1, "bp5");
    step(0, '0,      0, 0, 3, 0, 3, 1, "bp6");
    step(0, '0,      1, 0, 3, 1, 3, 1, "bp7");
    step(0, '0,      1, 0, 3, 1, 2, 1, "bp8");
    step(0, '0,      1, 0, 3, 1, 1, 1, "bp9");
    step(0, '0,      1, 0, 3, 1, 0, 0, "bp10");

    // Flush with count=3: no transfer during clr, then a fresh word takes DEPTH cycles.
    step(1, pat(20), 0, 0, 3, 1, 0, 0, "fl0");
    step(1, pat(21), 0, 0, 3, 1, 1, 0, "fl1");
    step(1, pat(22), 0, 0, 3, 1, 2, 0, "fl2");
    step(1, pat(23), 1, 1, 3, 0, 3, 0, "fl3");
    step(0, '0,      1, 0, 3, 1, 0, 0, "fl4");
    step(1, pat(24), 1, 0, 3, 1, 0, 0, "fl5");
    step(0, '0,      1, 0, 3, 1, 1, 0, "fl6");
    step(0, '0,      1, 0, 3, 1, 1, 0, "fl7");
    step(0, '0,      1, 0, 3, 1, 1, 1, "fl8");
    step(0, '0,      1, 0, 3, 1, 0, 0, "fl9");

    // Asynchronous reset with two words in flight.
    step(1, pat(30), 0, 0, 3, 1, 0, 0, "rs0");
    step(1, pat(31), 0, 0, 3, 1, 1, 0, "rs1");
    step(0, '0,      0, 0, 3, 1, 2, 0, "rs2");
    #1;
    chk("rs.pre_out_valid", 128'(a_ov), 128'(1));
    chk("rs.pre_out_data", a_od, pat(30));
    rst = 1'b1;
    #1;
    chk("rs.out_valid", 128'(a_ov), 128'(0));
    chk("rs.out_data", a_od, 128'(0));
    chk("rs.count", 128'(a_cnt), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, '0,      1, 0, 3, 1, 0, 0, "rs_rel");
    step(1, pat(32), 1, 0, 3, 1, 0, 0, "rs3");
    step(0, '0,      1, 0, 3, 1, 1, 0, "rs4");
    step(0, '0,      1, 0, 3, 1, 1, 0, "rs5");
    step(0, '0,      1, 0, 3, 1, 1, 1, "rs6");
    step(0, '0,      1, 0, 3, 1, 0, 0, "rs7");

    // Bubble collapse in DEPTH=4: two separated words end up packed in stages 3 and 2.
    idle(6);
    step(1, pat(40), 0, 0, 4, 1, 0, 0, "bb0");
    step(0, '0,      0, 0, 4, 1, 1, 0, "bb1");
    step(0, '0,      0, 0, 4, 1, 1, 0, "bb2");
    step(1, pat(41), 0, 0, 4, 1, 1, 0, "bb3");
    step(0, '0,      0, 0, 4, 1, 2, 1, "bb4");
    step(0, '0,      0, 0, 4, 1, 2, 1, "bb5");
    step(0, '0,      0, 0, 4, 1, 2, 1, "bb6");
    step(0, '0,      1, 0, 4, 1, 2, 1, "bb7");
    step(0, '0,      1, 0, 4, 1, 1, 1, "bb8");
    step(0, '0,      1, 0, 4, 1, 0, 0, "bb9");

    // DEPTH=1 with out_ready toggling: one word every two cycles.
    idle(6);
    for (int k = 0; k < 10; k++) begin
      int idx;
      idx = (k <= 1) ? k : (k / 2) + 1;
      step(1, 128'(32'h100 + idx), (k % 2) == 1, 0, 1,
           (k == 0) ? 1 : (k % 2), (k >= 1) ? 1 : 0, (k >= 1) ? 1 : 0,
           $sformatf("d1_%0d", k));
    end

    idle(10);
    @(negedge clk);
    chk("end.sb3_drained", 128'(q3.size()), 128'(0));
    chk("end.sb4_drained", 128'(q4.size()), 128'(0));
    chk("end.sb1_drained", 128'(q1.size()), 128'(0));
    chk("end.count3", 128'(a_cnt), 128'(0));
    chk("end.count4", 128'(b_cnt), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
